// File: rtl/jstk2_spi_if.sv
// Handshake and serial bus bundle between the PmodJSTK2 SPI master and its controller/slave side.
interface jstk2_spi_if;
    logic        START;
    logic [39:0] TX_DATA;
    logic        MISO;
    logic        SS;
    logic        SCLK;
    logic        MOSI;
    logic        BUSY;
    logic        DONE;
    logic [39:0] RX_DATA;
    logic [9:0]  X_POS;
    logic [9:0]  Y_POS;
    logic [1:0]  BTN;

    modport master (
        input  START, TX_DATA, MISO,
        output SS, SCLK, MOSI, BUSY, DONE, RX_DATA, X_POS, Y_POS, BTN
    );

    modport slave (
        output START, TX_DATA, MISO,
        input  SS, SCLK, MOSI, BUSY, DONE, RX_DATA, X_POS, Y_POS, BTN
    );
endinterface

// File: rtl/jstk2_spi_master.sv
// SPI mode-0 master running one 5-byte PmodJSTK2 transaction per START and decoding X/Y/buttons.
// SCLK is generated from a half-period enable tick on CLK; it is only ever a data output.
module jstk2_spi_master #(
    parameter int HALF_CNT    = 90,
    parameter int SS_LEAD_HP  = 2,
    parameter int BYTE_GAP_HP = 2,
    parameter int SS_TRAIL_HP = 2
) (
    input  logic         CLK,
    input  logic         RST,
    jstk2_spi_if.master  bus
);
    localparam int CNT_W = (HALF_CNT > 0) ? $clog2(HALF_CNT + 1) : 1;
    localparam int HP_W  = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] div_cnt;
    logic [HP_W-1:0]  hp_cnt;
    logic [2:0]       bit_cnt;
    logic [2:0]       byte_cnt;
    logic [39:0]      tx_sr;
    logic [39:0]      rx_sr;
    logic             tick;

    logic             ss_q, sclk_q, mosi_q, busy_q, done_q;
    logic [39:0]      rx_data_q;
    logic [9:0]       x_pos_q, y_pos_q;
    logic [1:0]       btn_q;

    assign tick = (div_cnt == CNT_W'(HALF_CNT));

    // NOTE: every register below is written with non-blocking assignments in one clocked
    // block, so each tick decision sees the pre-edge values of all state regardless of order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            hp_cnt    <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            x_pos_q   <= '0;
            y_pos_q   <= '0;
            btn_q     <= '0;
        end else begin
            done_q <= 1'b0;

            if (state == S_IDLE || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    mosi_q <= 1'b0;
                    if (bus.START) begin
                        tx_sr    <= bus.TX_DATA;
                        mosi_q   <= bus.TX_DATA[39];
                        ss_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        hp_cnt   <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        state    <= S_LEAD;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                S_LEAD: begin
                    if (tick) begin
                        if (hp_cnt == HP_W'(SS_LEAD_HP - 1)) begin
                            hp_cnt <= '0;
                            state  <= S_SHIFT;
                        end else begin
                            hp_cnt <= hp_cnt + 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_sr  <= {rx_sr[38:0], bus.MISO};
                        end else begin
                            sclk_q  <= 1'b0;
                            tx_sr   <= {tx_sr[38:0], 1'b0};
                            mosi_q  <= tx_sr[38];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_cnt == 3'd4) begin
                                    state <= S_TRAIL;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                    state    <= S_GAP;
                                end
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (tick) begin
                        if (hp_cnt == HP_W'(BYTE_GAP_HP - 1)) begin
                            hp_cnt <= '0;
                            state  <= S_SHIFT;
                        end else begin
                            hp_cnt <= hp_cnt + 1'b1;
                        end
                    end
                end

                S_TRAIL: begin
                    if (tick) begin
                        if (hp_cnt == HP_W'(SS_TRAIL_HP - 1)) begin
                            hp_cnt    <= '0;
                            ss_q      <= 1'b1;
                            mosi_q    <= 1'b0;
                            done_q    <= 1'b1;
                            rx_data_q <= rx_sr;
                            // Byte layout: b0=[39:32] b1=[31:24] b2=[23:16] b3=[15:8] b4=[7:0]
                            x_pos_q   <= {rx_sr[25:24], rx_sr[39:32]};
                            y_pos_q   <= {rx_sr[9:8],   rx_sr[23:16]};
                            btn_q     <= rx_sr[1:0];
                            state     <= S_IDLE;
                        end else begin
                            hp_cnt <= hp_cnt + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.SS      = ss_q;
    assign bus.SCLK    = sclk_q;
    assign bus.MOSI    = mosi_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.RX_DATA = rx_data_q;
    assign bus.X_POS   = x_pos_q;
    assign bus.Y_POS   = y_pos_q;
    assign bus.BTN     = btn_q;
endmodule
